fifo_bank_v3: RTL and testbench

- Parametrised multi-channel successor to the single-channel MMU FIFO: NUM_CH independent FIFOs of arbitrary (non-power-of-two) depth sharing one clock and reset.
- Used to buffer and skew activation/weight rows feeding the systolic array.
- Adds per-channel occupancy counts, almost-full/almost-empty thresholds, sticky overflow/underflow flags, synchronous flush, and a selectable show-ahead or registered read mode.

---
 rtl/fifo_bank_v3.sv | 107 ++++++++++
 tb/tb_fifo_bank_v3.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bank_v3.sv
// Bank of NUM_CH independent FIFOs with arbitrary depth, occupancy flags, sticky
// overflow/underflow flags, synchronous flush and show-ahead or registered read data.
module fifo_bank_v3 #(
  parameter int unsigned  DATA_WIDTH = 32,
  parameter int unsigned  FIFO_DEPTH = 70,
  parameter int unsigned  NUM_CH     = 4,
  parameter int unsigned  AFULL_TH   = 66,
  parameter int unsigned  AEMPTY_TH  = 4,
  parameter bit           OUT_REG    = 1'b0,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         err_clr_i,
  input  logic [NUM_CH-1:0]            wren_i,
  input  logic [NUM_CH-1:0]            rden_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_CH-1:0]            rvalid_o,
  output logic [NUM_CH-1:0]            full_o,
  output logic [NUM_CH-1:0]            empty_o,
  output logic [NUM_CH-1:0]            afull_o,
  output logic [NUM_CH-1:0]            aempty_o,
  output logic [NUM_CH*CNT_W-1:0]      count_o,
  output logic [NUM_CH-1:0]            ovf_o,
  output logic [NUM_CH-1:0]            udf_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d, udf_q, udf_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  full, empty, wacc, racc;

    // Flush suppresses acceptance and new violations; err_clr loses to a same-cycle violation.
    always_comb begin
      full     = (cnt_q == CNT_W'(FIFO_DEPTH));
      empty    = (cnt_q == '0);
      wacc     = ~flush_i & wren_i[c] & (~full | rden_i[c]);
      racc     = ~flush_i & rden_i[c] & ~empty;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q & ~err_clr_i;
      udf_d    = udf_q & ~err_clr_i;
      rvalid_d = 1'b0;
      rdata_d  = rdata_q;
      if (flush_i) begin
        wptr_d = '0;
        rptr_d = '0;
        cnt_d  = '0;
      end else begin
        if (wacc) wptr_d = (wptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
        if (racc) rptr_d = (rptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(wacc) - CNT_W'(racc);
        if (wren_i[c] & full & ~rden_i[c]) ovf_d = 1'b1;
        if (rden_i[c] & empty)             udf_d = 1'b1;
        if (racc) begin
          rvalid_d = 1'b1;
          rdata_d  = mem_q[rptr_q];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wptr_q   <= '0;
        rptr_q   <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
        udf_q    <= 1'b0;
        rvalid_q <= 1'b0;
        rdata_q  <= '0;
      end else begin
        wptr_q   <= wptr_d;
        rptr_q   <= rptr_d;
        cnt_q    <= cnt_d;
        ovf_q    <= ovf_d;
        udf_q    <= udf_d;
        rvalid_q <= rvalid_d;
        rdata_q  <= rdata_d;
      end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
      if (wacc && !rst) mem_q[wptr_q] <= wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
    end

    assign rdata_o[c*DATA_WIDTH +: DATA_WIDTH] = OUT_REG ? rdata_q : mem_q[rptr_q];
    assign rvalid_o[c]                         = OUT_REG ? rvalid_q : ~empty;
    assign full_o[c]                           = full;
    assign empty_o[c]                          = empty;
    assign afull_o[c]                          = (32'(cnt_q) >= AFULL_TH);
    assign aempty_o[c]                         = (32'(cnt_q) <= AEMPTY_TH);
    assign count_o[c*CNT_W +: CNT_W]           = cnt_q;
    assign ovf_o[c]                            = ovf_q;
    assign udf_o[c]                            = udf_q;
  end

endmodule

// File: tb/tb_fifo_bank_v3.sv
// Scoreboard bench for fifo_bank_v3: one show-ahead and one registered-read instance
// share stimulus; a queue-based reference model supplies all expected values.
module tb_fifo_bank_v3;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 70;
  localparam int unsigned NCH   = 4;
  localparam int unsigned AF_TH = 66;
  localparam int unsigned AE_TH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst, flush, err_clr;
  logic [NCH-1:0]    wren, rden;
  logic [NCH*DW-1:0] wdata;

  logic [NCH*DW-1:0] rdata_sa, rdata_rg;
  logic [NCH-1:0]    rvalid_sa, full_sa, empty_sa, afull_sa, aempty_sa, ovf_sa, udf_sa;
  logic [NCH-1:0]    rvalid_rg, full_rg, empty_rg, afull_rg, aempty_rg, ovf_rg, udf_rg;
  logic [NCH*CW-1:0] count_sa, count_rg;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  // Reference model: queue contents, sticky flags, registered-read expectations.
  logic [DW-1:0] mq     [NCH][$];
  logic [DW-1:0] rg_exp [NCH][$];
  logic [DW-1:0] rg_last[NCH];
  bit            m_ovf  [NCH];
  bit            m_udf  [NCH];

  always #5 clk = ~clk;

  fifo_bank_v3 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH), .AFULL_TH(AF_TH),
                 .AEMPTY_TH(AE_TH), .OUT_REG(1'b0)) u_sa (
    .clk(clk), .rst(rst), .flush_i(flush), .err_clr_i(err_clr), .wren_i(wren), .rden_i(rden),
    .wdata_i(wdata), .rdata_o(rdata_sa), .rvalid_o(rvalid_sa), .full_o(full_sa),
    .empty_o(empty_sa), .afull_o(afull_sa), .aempty_o(aempty_sa), .count_o(count_sa),
    .ovf_o(ovf_sa), .udf_o(udf_sa));

  fifo_bank_v3 #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .NUM_CH(NCH), .AFULL_TH(AF_TH),
                 .AEMPTY_TH(AE_TH), .OUT_REG(1'b1)) u_rg (
    .clk(clk), .rst(rst), .flush_i(flush), .err_clr_i(err_clr), .wren_i(wren), .rden_i(rden),
    .wdata_i(wdata), .rdata_o(rdata_rg), .rvalid_o(rvalid_rg), .full_o(full_rg),
    .empty_o(empty_rg), .afull_o(afull_rg), .aempty_o(aempty_rg), .count_o(count_rg),
    .ovf_o(ovf_rg), .udf_o(udf_rg));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [NCH*DW-1:0] put(input int ch, input logic [DW-1:0] d);
    logic [NCH*DW-1:0] v;
    v = '0;
    v[ch*DW +: DW] = d;
    return v;
  endfunction

  function automatic logic [CW-1:0] cnt_of(input logic [NCH*CW-1:0] v, input int ch);
    return v[ch*CW +: CW];
  endfunction

  function automatic logic [DW-1:0] dat_of(input logic [NCH*DW-1:0] v, input int ch);
    return v[ch*DW +: DW];
  endfunction

  // Model step applied right after the active edge, using the inputs that edge saw.
  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int  sz;
      bit  w, r;
      logic [DW-1:0] v;
      w  = wren[c];
      r  = rden[c];
      sz = mq[c].size();
      if (rst) begin
        mq[c].delete();
        rg_exp[c].delete();
        rg_last[c] = '0;
        m_ovf[c]   = 1'b0;
        m_udf[c]   = 1'b0;
      end else begin
        if (err_clr) begin
          m_ovf[c] = 1'b0;
          m_udf[c] = 1'b0;
        end
        if (flush) begin
          mq[c].delete();
        end else begin
          if (w && sz == DEPTH && !r) m_ovf[c] = 1'b1;
          if (r && sz == 0)           m_udf[c] = 1'b1;
          if (r && sz > 0) begin
            v = mq[c].pop_front();
            rg_exp[c].push_back(v);
            rg_last[c] = v;
          end
          if (w && (sz < DEPTH || r)) mq[c].push_back(wdata[c*DW +: DW]);
        end
      end
    end
    if (rst) mon_en = 1'b1;
  endtask

  // Called at a falling edge; drives inputs, steps the model at the rising edge,
  // and returns at the next falling edge.
  task automatic cyc(input logic [NCH-1:0] w, input logic [NCH-1:0] r, input logic fl,
                     input logic ec, input logic rs, input logic [NCH*DW-1:0] d);
    wren = w; rden = r; flush = fl; err_clr = ec; rst = rs; wdata = d;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Monitor: compares both instances against the model at every falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int c = 0; c < NCH; c++) begin
        int sz;
        sz = mq[c].size();
        chk($sformatf("sa_count[%0d]", c), 64'(cnt_of(count_sa, c)), 64'(sz));
        chk($sformatf("rg_count[%0d]", c), 64'(cnt_of(count_rg, c)), 64'(sz));
        chk($sformatf("full[%0d]", c),   64'(full_sa[c]),   64'(sz == DEPTH));
        chk($sformatf("empty[%0d]", c),  64'(empty_sa[c]),  64'(sz == 0));
        chk($sformatf("afull[%0d]", c),  64'(afull_sa[c]),  64'(sz >= AF_TH));
        chk($sformatf("aempty[%0d]", c), 64'(aempty_sa[c]), 64'(sz <= AE_TH));
        chk($sformatf("ovf[%0d]", c),    64'({ovf_sa[c], ovf_rg[c]}), 64'({2{m_ovf[c]}}));
        chk($sformatf("udf[%0d]", c),    64'({udf_sa[c], udf_rg[c]}), 64'({2{m_udf[c]}}));
        chk($sformatf("sa_rvalid[%0d]", c), 64'(rvalid_sa[c]), 64'(sz != 0));
        if (sz != 0)
          chk($sformatf("sa_head[%0d]", c), 64'(dat_of(rdata_sa, c)), 64'(mq[c][0]));
        if (rvalid_rg[c]) begin
          if (rg_exp[c].size() == 0) begin
            chk($sformatf("rg_spurious_rvalid[%0d]", c), 64'(1), 64'(0));
          end else begin
            logic [DW-1:0] e;
            e = rg_exp[c].pop_front();
            chk($sformatf("rg_rdata[%0d]", c), 64'(dat_of(rdata_rg, c)), 64'(e));
          end
        end else if (rg_exp[c].size() != 0) begin
          void'(rg_exp[c].pop_front());
          chk($sformatf("rg_missing_rvalid[%0d]", c), 64'(0), 64'(1));
        end
        chk($sformatf("rg_hold[%0d]", c), 64'(dat_of(rdata_rg, c)), 64'(rg_last[c]));
      end
    end
  end

  initial begin
    int pw, pr;
    rst = 1'b1; flush = 1'b0; err_clr = 1'b0; wren = '0; rden = '0; wdata = '0;
    @(negedge clk);
    cyc('0, '0, 0, 0, 1, '0);
    cyc('0, '0, 0, 0, 1, '0);
    chk("rst_empty",  64'(empty_sa),  64'(4'hF));
    chk("rst_aempty", 64'(aempty_sa), 64'(4'hF));
    chk("rst_full",   64'(full_sa),   64'(0));
    chk("rst_afull",  64'(afull_sa),  64'(0));
    chk("rst_count",  64'(count_sa),  64'(0));
    chk("rst_rvalid", 64'(rvalid_rg), 64'(0));

    // Basic ordered write/read on ch0.
    for (int i = 1; i <= 3; i++) cyc(4'b0001, '0, 0, 0, 0, put(0, DW'(32'h11 * i)));
    chk("ch0_count3", 64'(cnt_of(count_sa, 0)), 64'(3));
    chk("ch1_idle",   64'(cnt_of(count_sa, 1)), 64'(0));
    chk("ch0_head",   64'(dat_of(rdata_sa, 0)), 64'(32'h11));
    for (int i = 0; i < 3; i++) cyc('0, 4'b0001, 0, 0, 0, '0);
    chk("ch0_empty", 64'(empty_sa[0]), 64'(1));

    // Fill ch2 to depth, overflow, drain.
    for (int i = 0; i < DEPTH; i++) begin
      cyc(4'b0100, '0, 0, 0, 0, put(2, DW'($urandom)));
      if (i == AF_TH - 2) chk("afull_below", 64'(afull_sa[2]), 64'(0));
      if (i == AF_TH - 1) chk("afull_at",    64'(afull_sa[2]), 64'(1));
    end
    chk("ch2_full",  64'(full_sa[2]), 64'(1));
    chk("ch2_cnt70", 64'(cnt_of(count_sa, 2)), 64'(DEPTH));
    cyc(4'b0100, '0, 0, 0, 0, put(2, 32'hDEAD_BEEF));
    chk("ch2_ovf",   64'(ovf_sa[2]), 64'(1));
    chk("ch2_drop",  64'(cnt_of(count_sa, 2)), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) cyc('0, 4'b0100, 0, 0, 0, '0);
    cyc('0, '0, 0, 1, 0, '0);
    chk("ovf_clr", 64'(ovf_sa[2]), 64'(0));

    // Full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) cyc(4'b0100, '0, 0, 0, 0, put(2, DW'($urandom)));
    cyc(4'b0100, 4'b0100, 0, 0, 0, put(2, 32'hCAFE_0001));
    chk("full_both_cnt", 64'(cnt_of(count_sa, 2)), 64'(DEPTH));
    chk("full_both_ovf", 64'(ovf_sa[2]), 64'(0));
    for (int i = 0; i < DEPTH; i++) cyc('0, 4'b0100, 0, 0, 0, '0);

    // Empty with simultaneous write and read.
    cyc(4'b1000, 4'b1000, 0, 0, 0, put(3, 32'h0000_5555));
    chk("empty_both_cnt", 64'(cnt_of(count_sa, 3)), 64'(1));
    chk("empty_both_udf", 64'(udf_sa[3]), 64'(1));
    cyc('0, 4'b1000, 0, 0, 0, '0);

    // Pointer wrap on ch1.
    for (int i = 0; i < 50; i++) cyc(4'b0010, '0, 0, 0, 0, put(1, DW'($urandom)));
    for (int i = 0; i < 50; i++) cyc('0, 4'b0010, 0, 0, 0, '0);
    for (int i = 0; i < 40; i++) cyc(4'b0010, '0, 0, 0, 0, put(1, DW'($urandom)));
    for (int i = 0; i < 40; i++) cyc('0, 4'b0010, 0, 0, 0, '0);

    // Registered read pulse and hold.
    cyc(4'b0010, '0, 0, 0, 0, put(1, 32'hAB));
    cyc('0, 4'b0010, 0, 0, 0, '0);
    chk("rg_pulse", 64'(rvalid_rg[1]), 64'(1));
    chk("rg_data",  64'(dat_of(rdata_rg, 1)), 64'(32'hAB));
    cyc('0, '0, 0, 0, 0, '0);
    chk("rg_pulse_end", 64'(rvalid_rg[1]), 64'(0));
    chk("rg_data_hold", 64'(dat_of(rdata_rg, 1)), 64'(32'hAB));
    cyc('0, 4'b0010, 0, 0, 0, '0);
    chk("rg_empty_rd", 64'(rvalid_rg[1]), 64'(0));

    // Flush with a concurrent write; sticky flags survive.
    for (int i = 0; i < 5; i++) cyc(4'b0001, '0, 0, 0, 0, put(0, DW'($urandom)));
    cyc(4'b0001, '0, 1, 0, 0, put(0, 32'h7777));
    chk("flush_cnt",   64'(cnt_of(count_sa, 0)), 64'(0));
    chk("flush_empty", 64'(empty_sa[0]), 64'(1));
    chk("flush_udf",   64'(udf_sa), 64'(4'b1010));
    cyc(4'b0001, '0, 0, 0, 0, put(0, 32'h1234));
    chk("post_flush_head", 64'(dat_of(rdata_sa, 0)), 64'(32'h1234));
    cyc('0, 4'b0001, 0, 1, 0, '0);
    chk("errclr_udf", 64'(udf_sa), 64'(0));

    // Randomized traffic with occasional flush, err_clr and reset.
    for (int ph = 0; ph < 3; ph++) begin
      pw = (ph == 0) ? 75 : (ph == 1) ? 30 : 55;
      pr = (ph == 0) ? 30 : (ph == 1) ? 75 : 50;
      for (int n = 0; n < 900; n++) begin
        logic [NCH-1:0] w, r;
        for (int c = 0; c < NCH; c++) begin
          w[c] = ($urandom_range(99) < pw);
          r[c] = ($urandom_range(99) < pr);
        end
        cyc(w, r, ($urandom_range(199) == 0), ($urandom_range(49) == 0),
            ($urandom_range(599) == 0), {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)});
      end
    end

    // Reset in the middle of traffic.
    for (int i = 0; i < 6; i++) cyc(4'hF, 4'h0, 0, 0, 0, {4{DW'($urandom)}});
    cyc(4'hF, 4'hF, 0, 0, 1, {4{DW'($urandom)}});
    chk("midrst_cnt_sa", 64'(count_sa), 64'(0));
    chk("midrst_cnt_rg", 64'(count_rg), 64'(0));
    cyc('0, '0, 0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
